// File: rtl/fpop_pkg.sv
// rtl/fpop_pkg.sv - shared types and Q-format constants for the fpop issuer
package fpop_pkg;

  localparam int QBITS = 23;
  localparam int NBITS = 32;

  typedef enum logic [1:0] {
    ADD     = 2'b00,
    MUL     = 2'b01,
    DIV     = 2'b10,
    ILLEGAL = 2'b11
  } fpop_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } fpop_state_e;

  // One queued command: opcode followed by both operands.
  typedef struct packed {
    fpop_op_e         op;
    logic [NBITS-1:0] a;
    logic [NBITS-1:0] b;
  } fpop_cmd_t;

endpackage

// File: rtl/fpop_cmd_fifo.sv
// rtl/fpop_cmd_fifo.sv - command queue, registered count, no bypass
module fpop_cmd_fifo
  import fpop_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = $bits(fpop_cmd_t)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CAP = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CAP);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Storage write; contents need no reset since count guards every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fpop_issuer.sv
// rtl/fpop_issuer.sv - in-order issuer driving the arithmetic top, one op outstanding
module fpop_issuer
  import fpop_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int FIX_LAT     = 2,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_opcode,
  input  logic [NBITS-1:0] cmd_a,
  input  logic [NBITS-1:0] cmd_b,
  output logic [NBITS-1:0] alu_a,
  output logic [NBITS-1:0] alu_b,
  output logic [1:0]       alu_opcode,
  output logic             alu_start,
  input  logic [NBITS-1:0] alu_c,
  input  logic             alu_done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [NBITS-1:0] rsp_data,
  output logic             rsp_err
);

  localparam int QCW      = $clog2(FIFO_DEPTH) + 1;
  localparam int WAIT_MAX = (DIV_TIMEOUT > FIX_LAT) ? DIV_TIMEOUT : FIX_LAT;
  localparam int WCW      = $clog2(WAIT_MAX + 1);
  localparam logic [QCW-1:0] QUEUE_CAP = QCW'(FIFO_DEPTH);
  localparam logic [WCW-1:0] FIX_LAST  = WCW'(FIX_LAT - 1);
  localparam logic [WCW-1:0] DIV_LAST  = WCW'(DIV_TIMEOUT - 1);

  fpop_cmd_t       cmd_in;
  fpop_cmd_t       cmd_head;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [QCW-1:0]  fifo_count;

  fpop_state_e     state;
  fpop_op_e        cur_op;
  logic [WCW-1:0]  wait_cnt;

  assign cmd_in.op = fpop_op_e'(cmd_opcode);
  assign cmd_in.a  = cmd_a;
  assign cmd_in.b  = cmd_b;

  // Ready comes from the registered count only, so a same-cycle pop never frees a slot early.
  assign cmd_ready  = (fifo_count < QUEUE_CAP);
  assign fifo_push  = cmd_valid && !fifo_full;
  assign fifo_pop   = (state == IDLE) && !fifo_empty;
  assign alu_opcode = cur_op;

  fpop_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fpop_cmd_t))
  ) u_cmd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (cmd_in),
    .rdata (cmd_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Issue FSM: pop, pulse start, wait for a fixed latency or divider completion, hold the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur_op    <= ADD;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_start <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      alu_start <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            cur_op   <= cmd_head.op;
            alu_a    <= cmd_head.a;
            alu_b    <= cmd_head.b;
            wait_cnt <= '0;
            if (cmd_head.op == ILLEGAL) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
            end else begin
              state     <= ISSUE;
              alu_start <= 1'b1;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + WCW'(1);
          if (cur_op == DIV) begin
            if (alu_done) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_data  <= alu_c;
            end else if (wait_cnt == DIV_LAST) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
            end
          end else if (wait_cnt == FIX_LAST) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= alu_c;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpop_issuer.sv
// tb/tb_fpop_issuer.sv - randomized scoreboard bench for fpop_issuer
module tb_fpop_issuer;

  localparam int FIFO_DEPTH  = 4;
  localparam int FIX_LAT     = 2;
  localparam int DIV_TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_opcode;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [1:0]  alu_opcode;
  logic        alu_start;
  logic [31:0] alu_c;
  logic        alu_done;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          dly;
  } cmd_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  cmd_t iq[$];
  rsp_t rq[$];
  int   starts     = 0;
  int   ready_mode = 0;

  always #5 clk = ~clk;

  fpop_issuer #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .FIX_LAT     (FIX_LAT),
    .DIV_TIMEOUT (DIV_TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_start  (alu_start),
    .alu_c      (alu_c),
    .alu_done   (alu_done),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic rsp_t expect_rsp(input cmd_t c);
    rsp_t r;
    if (c.op == 2'b11 || (c.op == 2'b10 && c.dly == 0)) begin
      r.data = 32'h0;
      r.err  = 1'b1;
    end else begin
      r.data = c.res;
      r.err  = 1'b0;
    end
    return r;
  endfunction

  task automatic push_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input int dly);
    cmd_t c;
    int   guard;
    c          = '{op, a, b, res, dly};
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    guard      = 0;
    while (!cmd_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      chk("push_wait", 32'(cmd_ready), 32'h1);
      cmd_valid = 1'b0;
      return;
    end
    if (op != 2'b11) iq.push_back(c);
    rq.push_back(expect_rsp(c));
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    ready_mode = 1;
    while ((rq.size() != 0 || rsp_valid) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("drain_left", 32'(rq.size()), 32'h0);
    ready_mode = 0;
    @(negedge clk);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Consumer handshake driver.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      rsp_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    end
  end

  // Arithmetic-top model: result valid FIX_LAT edges after start, divider done after dly edges.
  initial begin
    cmd_t cur;
    int   k;
    int   limit;
    bit   active;
    alu_c    = 32'h0;
    alu_done = 1'b0;
    active   = 1'b0;
    k        = 0;
    limit    = 0;
    cur      = '{2'b00, 32'h0, 32'h0, 32'h0, 0};
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        active   = 1'b0;
        alu_done = 1'($urandom_range(0, 1));
        alu_c    = $urandom;
      end else if (alu_start) begin
        starts++;
        if (iq.size() == 0) begin
          chk("unexpected_start", 32'(alu_start), 32'h0);
          active = 1'b0;
        end else begin
          cur = iq.pop_front();
          chk("issue_op", 32'(alu_opcode), 32'(cur.op));
          chk("issue_a", alu_a, cur.a);
          chk("issue_b", alu_b, cur.b);
          active = 1'b1;
          k      = 0;
          limit  = (cur.op == 2'b10) ? ((cur.dly != 0) ? cur.dly : DIV_TIMEOUT) : FIX_LAT;
        end
        alu_done = 1'($urandom_range(0, 1));
        alu_c    = $urandom;
      end else if (active) begin
        k++;
        if (k <= limit) begin
          chk("hold_op", 32'(alu_opcode), 32'(cur.op));
          chk("hold_a", alu_a, cur.a);
          chk("hold_b", alu_b, cur.b);
        end
        if (cur.op != 2'b10) begin
          alu_c    = (k == FIX_LAT) ? cur.res : $urandom;
          alu_done = 1'($urandom_range(0, 1));
        end else if (cur.dly != 0 && k == cur.dly) begin
          alu_done = 1'b1;
          alu_c    = cur.res;
        end else if (k <= limit) begin
          alu_done = 1'b0;
          alu_c    = $urandom;
        end else begin
          alu_done = (k == limit + 1) ? 1'b1 : 1'($urandom_range(0, 1));
          alu_c    = $urandom;
        end
      end else begin
        alu_done = 1'($urandom_range(0, 1));
        alu_c    = $urandom;
      end
    end
  end

  // Response scoreboard: order, contents, and stability while stalled.
  initial begin
    rsp_t        e;
    bit          pv;
    bit          phs;
    logic [31:0] pd;
    logic        pe;
    pv  = 1'b0;
    phs = 1'b0;
    pd  = 32'h0;
    pe  = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        pv = 1'b0;
        continue;
      end
      if (pv && !phs) begin
        chk("rsp_hold_valid", 32'(rsp_valid), 32'h1);
        if (rsp_valid) begin
          chk("rsp_hold_data", rsp_data, pd);
          chk("rsp_hold_err", 32'(rsp_err), 32'(pe));
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (rq.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
        end else begin
          e = rq.pop_front();
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
      pv  = rsp_valid;
      phs = rsp_valid && rsp_ready;
      pd  = rsp_data;
      pe  = rsp_err;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int s0;
    int ok;
    logic [1:0] op;
    int dly;

    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_opcode = 2'b00;
    cmd_a      = 32'h0;
    cmd_b      = 32'h0;
    repeat (3) @(negedge clk);

    chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_alu_start", 32'(alu_start), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_b", alu_b, 32'h0);
    chk("rst_alu_opcode", 32'(alu_opcode), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Add 1.5 + 2.25 with fixed-latency result.
    ready_mode = 0;
    s0 = starts;
    push_cmd(2'b00, 32'h00C00000, 32'h01200000, 32'h01E00000, 0);
    wait_rsp(n);
    chk("add_latency", 32'(n), 32'(2 + FIX_LAT));
    chk("add_data", rsp_data, 32'h01E00000);
    chk("add_err", 32'(rsp_err), 32'h0);
    chk("add_starts", 32'(starts - s0), 32'h1);
    repeat (4) @(negedge clk);
    drain();

    // Divide completing 10 cycles after start, stray done while response is held.
    push_cmd(2'b10, 32'h00800000, 32'h01000000, 32'h00400000, 10);
    wait_rsp(n);
    chk("div_latency", 32'(n), 32'(2 + 10));
    repeat (5) @(negedge clk);
    chk("div_data", rsp_data, 32'h00400000);
    chk("div_err", 32'(rsp_err), 32'h0);
    drain();

    // Divide that never completes.
    push_cmd(2'b10, 32'h00400000, 32'h0, 32'h12345678, 0);
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("div_timeout_latency", 32'(n), 32'(2 + DIV_TIMEOUT));
    chk("div_timeout_err", 32'(rsp_err), 32'h1);
    chk("div_timeout_data", rsp_data, 32'h0);
    drain();

    // Illegal opcode followed by an Add.
    s0 = starts;
    push_cmd(2'b11, 32'hDEADBEEF, 32'hCAFEF00D, 32'h0, 0);
    push_cmd(2'b00, 32'h00200000, 32'h00600000, 32'h00800000, 0);
    wait_rsp(n);
    chk("ill_err", 32'(rsp_err), 32'h1);
    chk("ill_data", rsp_data, 32'h0);
    drain();
    chk("ill_starts", 32'(starts - s0), 32'h1);

    // Fill the queue behind a stalled response.
    ready_mode = 0;
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      push_cmd(2'(i % 2), $urandom, $urandom, $urandom, 0);
    end
    repeat (8) @(negedge clk);
    chk("full_cmd_ready", 32'(cmd_ready), 32'h0);
    chk("full_rsp_valid", 32'(rsp_valid), 32'h1);
    drain();
    chk("after_drain_ready", 32'(cmd_ready), 32'h1);

    // Reset while a divide waits with three commands queued.
    ready_mode = 0;
    push_cmd(2'b10, 32'h00100000, 32'h00200000, 32'h0, 0);
    for (int i = 0; i < 3; i++) begin
      push_cmd(2'b01, $urandom, $urandom, $urandom, 0);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    iq.delete();
    rq.delete();
    @(negedge clk);
    reset = 1'b0;
    ok = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid || alu_start || !cmd_ready) ok = 0;
    end
    chk("rst_mid_quiet", 32'(ok), 32'h1);
    chk("rst_mid_ready", 32'(cmd_ready), 32'h1);
    chk("rst_mid_start", 32'(alu_start), 32'h0);

    // Randomized traffic with random back-pressure.
    ready_mode = 2;
    for (int i = 0; i < 80; i++) begin
      op  = 2'($urandom_range(0, 3));
      dly = 0;
      if (op == 2'b10) dly = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 20));
      push_cmd(op, $urandom, $urandom, $urandom, dly);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    chk("issue_queue_empty", 32'(iq.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
